// File: rtl/flags_pkg.sv
// Shared definitions for the flags register sequencer:
// flag bit positions, condition codes, FSM states.
package flags_pkg;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [2:0] COND_AL = 3'd0;
    localparam logic [2:0] COND_Z  = 3'd1;
    localparam logic [2:0] COND_NZ = 3'd2;
    localparam logic [2:0] COND_C  = 3'd3;
    localparam logic [2:0] COND_NC = 3'd4;
    localparam logic [2:0] COND_N  = 3'd5;
    localparam logic [2:0] COND_V  = 3'd6;
    localparam logic [2:0] COND_LT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    function automatic logic cond_eval(
        input logic [3:0] f,
        input logic [2:0] sel
    );
        logic r;
        unique case (sel)
            COND_AL: r = 1'b1;
            COND_Z:  r = f[FLAG_Z];
            COND_NZ: r = ~f[FLAG_Z];
            COND_C:  r = f[FLAG_C];
            COND_NC: r = ~f[FLAG_C];
            COND_N:  r = f[FLAG_N];
            COND_V:  r = f[FLAG_V];
            default: r = f[FLAG_N] ^ f[FLAG_V];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flags_stack.sv
// DEPTH x 4 LIFO shadow stack for saved flags.
// Saturating pointer; clr empties it synchronously.
module flags_stack #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic [3:0] top,
    output logic       empty,
    output logic       full
);

    logic [3:0]  mem_q [DEPTH];
    logic [PW:0] ptr_q;
    logic [PW:0] ptr_m1;

    assign ptr_m1 = ptr_q - (PW+1)'(1);
    assign empty  = (ptr_q == '0);
    assign full   = (ptr_q == (PW+1)'(DEPTH));
    assign top    = mem_q[ptr_m1[PW-1:0]];

    // Pointer update; push and pop never wrap past the ends.
    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_q <= '0;
        end else if (push && !full) begin
            ptr_q <= ptr_q + (PW+1)'(1);
        end else if (pop && !empty) begin
            ptr_q <= ptr_m1;
        end
    end

    // Entry storage; written at the current pointer on push.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem_q[ptr_q[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/flags_seq.sv
// Flags register strobe sequencer with interrupt save/restore.
// Optional condition evaluator enabled by FLAGS_SEQ_COND_EN.
module flags_seq
    import flags_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uop_calc,
    input  logic       uop_load,
    input  logic       uop_out,
    input  logic       irq_save,
    input  logic       irq_restore,
    input  logic       err_clr,
    input  logic [3:0] fin,
    input  logic [2:0] cond_sel,
    output logic       calcn,
    output logic       bloadn,
    output logic       boutn,
    output logic       rst_oen_n,
    output logic [3:0] rst_data,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       err_ovf,
    output logic       err_unf,
    output logic       err_drop,
    output logic       err_conf,
    output logic       cond_true
);

    state_e     state_q, state_d;
    logic       push, pop;
    logic       ovf_s, unf_s, drop_s, conf_s;
    logic       uop_any;
    logic [3:0] top;
    logic       ovf_q, unf_q, drop_q, conf_q;

    flags_stack #(
        .DEPTH(DEPTH),
        .PW   (PW)
    ) u_stack (
        .clk  (clk),
        .clr  (reset),
        .push (push),
        .pop  (pop),
        .din  (fin),
        .top  (top),
        .empty(empty),
        .full (full)
    );

    assign uop_any = uop_calc | uop_load | uop_out;
    assign busy    = (state_q != ST_IDLE);

    // Next state, stack control, error events and strobes.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_s     = 1'b0;
        unf_s     = 1'b0;
        drop_s    = 1'b0;
        conf_s    = 1'b0;
        calcn     = 1'b1;
        bloadn    = 1'b1;
        boutn     = 1'b1;
        rst_oen_n = 1'b1;
        rst_data  = 4'd0;
        unique case (state_q)
            ST_IDLE: begin
                if (irq_save) begin
                    if (full) ovf_s = 1'b1;
                    else      push  = 1'b1;
                end
                if (irq_restore) begin
                    if (irq_save)   drop_s  = 1'b1;
                    else if (empty) unf_s   = 1'b1;
                    else            state_d = ST_PEND;
                end
                conf_s = uop_calc & uop_load;
            end
            ST_PEND: begin
                drop_s = irq_save | irq_restore;
                conf_s = uop_calc & uop_load;
                if (!uop_any) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                drop_s  = irq_save | irq_restore;
                conf_s  = uop_any;
                pop     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q == ST_DRIVE) begin
            bloadn    = 1'b0;
            rst_oen_n = 1'b0;
            rst_data  = top;
        end else begin
            calcn  = ~uop_calc;
            bloadn = ~(uop_load & ~uop_calc);
            boutn  = ~uop_out;
        end
        // Reset aborts any restore: no strobe, no stack movement.
        if (reset) begin
            push      = 1'b0;
            pop       = 1'b0;
            calcn     = 1'b1;
            bloadn    = 1'b1;
            boutn     = 1'b1;
            rst_oen_n = 1'b1;
            rst_data  = 4'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Sticky errors; clear beats a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            drop_q <= 1'b0;
            conf_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_q  | ovf_s;
            unf_q  <= unf_q  | unf_s;
            drop_q <= drop_q | drop_s;
            conf_q <= conf_q | conf_s;
        end
    end

    assign err_ovf  = ovf_q;
    assign err_unf  = unf_q;
    assign err_drop = drop_q;
    assign err_conf = conf_q;

`ifdef FLAGS_SEQ_COND_EN
    logic cond_q;

    // Registered condition result from the live flags.
    always_ff @(posedge clk) begin
        if (reset) cond_q <= 1'b0;
        else       cond_q <= cond_eval(fin, cond_sel);
    end

    assign cond_true = cond_q;
`else
    logic unused_cond_sel;

    assign unused_cond_sel = ^cond_sel;
    assign cond_true       = 1'b0;
`endif

endmodule

// File: doc/flags_seq.md
# flags_seq

Sequencer and arbiter for the 4-bit flags register. Converts microcode flag requests into the register's active-low strobes (calcn, bloadn, boutn). Keeps a small LIFO shadow stack so interrupt entry can save the flags and interrupt return can restore them through a bus-load cycle. Sits between the microcode decoder / interrupt controller and the flags register, sharing that register's bus-load path between microcode and the restore engine.

## Interface
- DEPTH, 4: shadow stack entries (2..16).
- PW, 2: stack pointer width; must satisfy 2**PW == DEPTH.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- uop_calc  in  1  microcode: load flags from ALU this cycle.
- uop_load  in  1  microcode: load flags from bus[3:0] this cycle.
- uop_out  in  1  microcode: drive flags onto bus this cycle.
- irq_save  in  1  single-cycle request: push current flags.
- irq_restore  in  1  single-cycle request: pop and reload flags.
- err_clr  in  1  clears sticky errors.
- fin  in  4  flags register output {V,C,Z,N} (bit0 = N).
- cond_sel  in  3  condition select.
- calcn, bloadn, boutn  out  1 each  active-low flags register strobes.
- rst_oen_n  out  1  active-low enable of the restore-data bus driver.
- rst_data  out  4  nibble driven onto bus[3:0] during restore.
- busy  out  1  restore pending or in progress.
- empty, full  out  1 each  shadow stack status.
- err_ovf, err_unf, err_drop, err_conf  out  1 each  sticky error flags.
- cond_true  out  1  registered condition result.

## Operation
- FSM states: IDLE, PEND, DRIVE.
- Strobes are combinational from the current inputs and state.
  - uop_calc: calcn=0, bloadn=1.
  - uop_load without uop_calc: bloadn=0.
  - uop_calc and uop_load together: calc wins (calcn=0, bloadn=1) and err_conf is set.
  - uop_out: boutn=0.
- Save: irq_save accepted only while busy=0.
  - Not full: fin is pushed on that edge, with zero extra latency.
  - Full: the push is dropped and err_ovf is set.
- Restore: irq_restore accepted only while busy=0.
  - Stack empty: the request is ignored and err_unf is set.
  - Stack non-empty: IDLE→PEND.
- PEND→DRIVE on any edge where uop_calc, uop_load and uop_out are all 0. Otherwise PEND holds (microcode has priority; there is no timeout).
- DRIVE lasts one cycle.
  - Outputs: rst_oen_n=0, rst_data=top entry, bloadn=0, calcn=1, boutn=1.
  - Flags register captures on the closing edge; the pointer decrements on that same edge; next state is IDLE.
- Microcode requests arriving while in DRIVE are not possible by construction. The restore only enters DRIVE from a free cycle, and microcode must honour busy by not issuing flag ops during a DRIVE cycle. If any uop_* is asserted in DRIVE, err_conf is set; the restore strobes still take precedence.
- irq_save or irq_restore while busy=1: ignored, err_drop is set.
- irq_save and irq_restore in the same cycle (busy=0): the save is performed, the restore is ignored, and err_drop is set.
- err_* are cleared by err_clr (err_clr wins over a same-cycle set) or by reset.
- Condition codes: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 V, 7 N^V.

## Timing
- Reset values:
  - State IDLE, pointer 0, empty=1, full=0, busy=0.
  - All err_*=0, cond_true=0.
  - calcn=bloadn=boutn=1, rst_oen_n=1, rst_data=0.
- Reset mid-restore (PEND or DRIVE) aborts the restore: no load occurs and the stack is cleared.
- busy rises on the edge that accepts irq_restore. It falls on the edge ending DRIVE.
- Minimum restore latency: the request edge, plus one PEND edge, plus one DRIVE cycle. The flags are visible on fin after the register's own output latency.
- Push/pop pointers saturate and never wrap. full when pointer == DEPTH; empty when pointer == 0. The pointer is PW+1 bits internally.

## Configuration
- FLAGS_SEQ_COND_EN defined: cond_true is registered each edge from cond_sel applied to fin (1-cycle latency).
- Not defined: the evaluator is removed and cond_true is tied to 0. cond_sel is unused.

## Structure
- Shared package/include flags_pkg holds:
  - flag bit indices FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3;
  - condition codes COND_*;
  - FSM state encodings.
- Sub-module flags_stack: a DEPTH×4 LIFO with push, pop, top, empty and full, and a synchronous clear. The FSM, strobe logic and condition evaluator stay in flags_seq.

## Test plan
- Reset, then idle: all strobes=1, rst_oen_n=1, empty=1, busy=0, errors=0.
- fin=4'b0110, irq_save; then fin=4'b0001, irq_restore with no uops → two cycles later the DRIVE cycle shows rst_data=4'b0110, bloadn=0, calcn=1; empty=1 after.
- irq_restore while uop_calc is held high for 3 cycles → busy stays 1 and there is no DRIVE until uop_calc drops; then exactly one DRIVE cycle.
- Push 5 times with DEPTH=4 → full=1 after 4 pushes, 5th sets err_ovf; 5 pops restore the values in reverse order, the 5th sets err_unf.
- uop_calc=1 and uop_load=1 together → calcn=0, bloadn=1, err_conf=1; err_clr → 0.
- With FLAGS_SEQ_COND_EN: fin=4'b1000 (V), cond_sel=7 → cond_true=1 next cycle; fin=4'b1001 → 0. Without the macro, cond_true stays 0.
